// File: rtl/id_stage_pipe.sv
// id_stage_pipe: OpenMIPS decode stage. It decodes logic, shift, add/sub,
// set-less-than and load-word instructions, resolves each source through
// prioritised forwarding ports, raises a load-use interlock, and holds the
// result in an integrated ID/EX pipeline register.
module id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_PORTS  = 2,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid_i,
  input  logic [DATA_W-1:0]               pc_i,
  input  logic [31:0]                     inst_i,
  output logic [REG_ADDR_W-1:0]           reg1_addr_o,
  output logic [REG_ADDR_W-1:0]           reg2_addr_o,
  output logic                            reg1_read_o,
  output logic                            reg2_read_o,
  input  logic [DATA_W-1:0]               reg1_data_i,
  input  logic [DATA_W-1:0]               reg2_data_i,
  input  logic [FWD_PORTS-1:0]            fwd_wreg_i,
  input  logic [FWD_PORTS*REG_ADDR_W-1:0] fwd_wd_i,
  input  logic [FWD_PORTS*DATA_W-1:0]     fwd_wdata_i,
  input  logic                            ex_load_i,
  input  logic [REG_ADDR_W-1:0]           ex_load_wd_i,
  input  logic                            stall_i,
  input  logic                            flush_i,
  output logic                            stallreq_o,
  output logic [7:0]                      ex_aluop_o,
  output logic [2:0]                      ex_alusel_o,
  output logic [DATA_W-1:0]               ex_reg1_o,
  output logic [DATA_W-1:0]               ex_reg2_o,
  output logic [REG_ADDR_W-1:0]           ex_wd_o,
  output logic                            ex_wreg_o,
  output logic [DATA_W-1:0]               ex_pc_o,
  output logic                            ex_valid_o,
  output logic                            invalid_inst_o,
  output logic [CNT_W-1:0]                stall_cnt_o
);

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_LW      = 6'b100011;

  // SPECIAL function codes
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;

  // ALU operation codes shared with ex (variable shifts reuse the shift ops)
  localparam logic [7:0] ALU_NOP   = 8'b00000000;
  localparam logic [7:0] ALU_OR    = 8'b00100101;
  localparam logic [7:0] ALU_AND   = 8'b00100100;
  localparam logic [7:0] ALU_XOR   = 8'b00100110;
  localparam logic [7:0] ALU_NOR   = 8'b00100111;
  localparam logic [7:0] ALU_SLL   = 8'b01111100;
  localparam logic [7:0] ALU_SRL   = 8'b00000010;
  localparam logic [7:0] ALU_SRA   = 8'b00000011;
  localparam logic [7:0] ALU_ADDU  = 8'b00100001;
  localparam logic [7:0] ALU_SUBU  = 8'b00100011;
  localparam logic [7:0] ALU_SLT   = 8'b00101010;
  localparam logic [7:0] ALU_ADDIU = 8'b01010110;
  localparam logic [7:0] ALU_LW    = 8'b11100011;

  // Result selectors shared with ex
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;
  localparam logic [2:0] SEL_LOAD  = 3'b111;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

  // Instruction fields
  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, sa_s;
  logic [15:0] imm_s;

  assign op_s    = inst_i[31:26];
  assign rs_s    = inst_i[25:21];
  assign rt_s    = inst_i[20:16];
  assign rd_s    = inst_i[15:11];
  assign sa_s    = inst_i[10:6];
  assign funct_s = inst_i[5:0];
  assign imm_s   = inst_i[15:0];

  // Raw decode results
  logic                  dec_ok_s, re1_s, re2_s;
  logic [7:0]            aluop_s;
  logic [2:0]            alusel_s;
  logic [DATA_W-1:0]     imm_ext_s;
  logic [REG_ADDR_W-1:0] wd_s;

  // Gated reads, resolved operands and interlock
  logic              rd_en_s, stallreq_s;
  logic [DATA_W-1:0] op1_s, op2_s;

  // ID/EX register state and next state
  logic [7:0]            ex_aluop_q, ex_aluop_d;
  logic [2:0]            ex_alusel_q, ex_alusel_d;
  logic [DATA_W-1:0]     ex_reg1_q, ex_reg1_d, ex_reg2_q, ex_reg2_d;
  logic [REG_ADDR_W-1:0] ex_wd_q, ex_wd_d;
  logic                  ex_wreg_q, ex_wreg_d;
  logic [DATA_W-1:0]     ex_pc_q, ex_pc_d;
  logic                  ex_valid_q, ex_valid_d;
  logic                  invalid_q, invalid_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  // Source value: $0 reads as zero; otherwise the lowest-index matching port wins
  function automatic logic [DATA_W-1:0] resolve_src(
    input logic [REG_ADDR_W-1:0]           addr,
    input logic [DATA_W-1:0]               rf_data,
    input logic [FWD_PORTS-1:0]            wreg,
    input logic [FWD_PORTS*REG_ADDR_W-1:0] wd,
    input logic [FWD_PORTS*DATA_W-1:0]     wdata
  );
    logic [DATA_W-1:0] val;
    val = rf_data;
    for (int k = FWD_PORTS - 1; k >= 0; k--) begin
      val = (wreg[k] && (wd[k*REG_ADDR_W +: REG_ADDR_W] == addr))
            ? wdata[k*DATA_W +: DATA_W] : val;
    end
    return (addr == REG_ZERO) ? {DATA_W{1'b0}} : val;
  endfunction

  // Decode the instruction word into op, select, sources, immediate and destination
  always_comb begin
    dec_ok_s  = 1'b0;
    aluop_s   = ALU_NOP;
    alusel_s  = SEL_NOP;
    re1_s     = 1'b0;
    re2_s     = 1'b0;
    imm_ext_s = {DATA_W{1'b0}};
    wd_s      = REG_ZERO;
    if (op_s == OP_SPECIAL) begin
      wd_s = REG_ADDR_W'(rd_s);
      if ((rs_s == 5'd0) && ((funct_s == FN_SLL) || (funct_s == FN_SRL) || (funct_s == FN_SRA))) begin
        // Shift by immediate: reg1 carries the zero-extended shift amount
        dec_ok_s  = 1'b1;
        re2_s     = 1'b1;
        imm_ext_s = DATA_W'(sa_s);
        alusel_s  = SEL_SHIFT;
        case (funct_s)
          FN_SLL:  aluop_s = ALU_SLL;
          FN_SRL:  aluop_s = ALU_SRL;
          default: aluop_s = ALU_SRA;
        endcase
      end else if (sa_s == 5'd0) begin
        re1_s    = 1'b1;
        re2_s    = 1'b1;
        dec_ok_s = 1'b1;
        case (funct_s)
          FN_OR:   begin aluop_s = ALU_OR;   alusel_s = SEL_LOGIC; end
          FN_AND:  begin aluop_s = ALU_AND;  alusel_s = SEL_LOGIC; end
          FN_XOR:  begin aluop_s = ALU_XOR;  alusel_s = SEL_LOGIC; end
          FN_NOR:  begin aluop_s = ALU_NOR;  alusel_s = SEL_LOGIC; end
          FN_SLLV: begin aluop_s = ALU_SLL;  alusel_s = SEL_SHIFT; end
          FN_SRLV: begin aluop_s = ALU_SRL;  alusel_s = SEL_SHIFT; end
          FN_SRAV: begin aluop_s = ALU_SRA;  alusel_s = SEL_SHIFT; end
          FN_ADDU: begin aluop_s = ALU_ADDU; alusel_s = SEL_ARITH; end
          FN_SUBU: begin aluop_s = ALU_SUBU; alusel_s = SEL_ARITH; end
          FN_SLT:  begin aluop_s = ALU_SLT;  alusel_s = SEL_ARITH; end
          default: dec_ok_s = 1'b0;
        endcase
      end else begin
        dec_ok_s = 1'b0;
      end
    end else begin
      // I-type: rs feeds reg1, the extended immediate feeds reg2, rt is written
      re1_s    = 1'b1;
      dec_ok_s = 1'b1;
      wd_s     = REG_ADDR_W'(rt_s);
      case (op_s)
        OP_ORI:   begin aluop_s = ALU_OR;    alusel_s = SEL_LOGIC; imm_ext_s = DATA_W'(imm_s); end
        OP_ANDI:  begin aluop_s = ALU_AND;   alusel_s = SEL_LOGIC; imm_ext_s = DATA_W'(imm_s); end
        OP_XORI:  begin aluop_s = ALU_XOR;   alusel_s = SEL_LOGIC; imm_ext_s = DATA_W'(imm_s); end
        OP_LUI:   begin aluop_s = ALU_OR;    alusel_s = SEL_LOGIC; imm_ext_s = DATA_W'({imm_s, 16'h0000}); end
        OP_ADDIU: begin aluop_s = ALU_ADDIU; alusel_s = SEL_ARITH; imm_ext_s = DATA_W'($signed(imm_s)); end
        OP_SLTI:  begin aluop_s = ALU_SLT;   alusel_s = SEL_ARITH; imm_ext_s = DATA_W'($signed(imm_s)); end
        OP_LW:    begin aluop_s = ALU_LW;    alusel_s = SEL_LOAD;  imm_ext_s = DATA_W'($signed(imm_s)); end
        default:  begin re1_s = 1'b0; dec_ok_s = 1'b0; end
      endcase
    end
  end

  // Only a real, decodable instruction reads the regfile; disabled reads present address 0
  assign rd_en_s     = id_valid_i & dec_ok_s;
  assign reg1_read_o = rd_en_s & re1_s;
  assign reg2_read_o = rd_en_s & re2_s;
  assign reg1_addr_o = reg1_read_o ? REG_ADDR_W'(rs_s) : REG_ZERO;
  assign reg2_addr_o = reg2_read_o ? REG_ADDR_W'(rt_s) : REG_ZERO;

  // Operand selection: forwarded/regfile value for enabled reads, immediate otherwise
  always_comb begin
    if (reg1_read_o) begin
      op1_s = resolve_src(reg1_addr_o, reg1_data_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i);
    end else begin
      op1_s = imm_ext_s;
    end
    if (reg2_read_o) begin
      op2_s = resolve_src(reg2_addr_o, reg2_data_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i);
    end else begin
      op2_s = imm_ext_s;
    end
  end

  // Load-use interlock; reads of $0 never match because the load target must be nonzero
  assign stallreq_s = ~rst & id_valid_i & ex_load_i & (ex_load_wd_i != REG_ZERO) &
                      ((reg1_read_o & (reg1_addr_o == ex_load_wd_i)) |
                       (reg2_read_o & (reg2_addr_o == ex_load_wd_i)));
  assign stallreq_o = stallreq_s;

  // Next ID/EX contents: flush, then hold, then interlock/empty bubble, then decode
  always_comb begin
    ex_aluop_d  = ALU_NOP;
    ex_alusel_d = SEL_NOP;
    ex_reg1_d   = {DATA_W{1'b0}};
    ex_reg2_d   = {DATA_W{1'b0}};
    ex_wd_d     = REG_ZERO;
    ex_wreg_d   = 1'b0;
    ex_pc_d     = {DATA_W{1'b0}};
    ex_valid_d  = 1'b0;
    invalid_d   = 1'b0;
    if (flush_i) begin
      invalid_d = 1'b0;
    end else if (stall_i) begin
      ex_aluop_d  = ex_aluop_q;
      ex_alusel_d = ex_alusel_q;
      ex_reg1_d   = ex_reg1_q;
      ex_reg2_d   = ex_reg2_q;
      ex_wd_d     = ex_wd_q;
      ex_wreg_d   = ex_wreg_q;
      ex_pc_d     = ex_pc_q;
      ex_valid_d  = ex_valid_q;
    end else if (stallreq_s || !id_valid_i) begin
      invalid_d = 1'b0;
    end else if (!dec_ok_s) begin
      invalid_d = 1'b1;
    end else begin
      ex_aluop_d  = aluop_s;
      ex_alusel_d = alusel_s;
      ex_reg1_d   = op1_s;
      ex_reg2_d   = op2_s;
      ex_wd_d     = wd_s;
      ex_wreg_d   = (wd_s != REG_ZERO);
      ex_pc_d     = pc_i;
      ex_valid_d  = 1'b1;
    end
  end

  // Saturating count of cycles spent requesting an interlock stall
  always_comb begin
    if (stallreq_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // ID/EX pipeline register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_aluop_q  <= ALU_NOP;
      ex_alusel_q <= SEL_NOP;
      ex_reg1_q   <= {DATA_W{1'b0}};
      ex_reg2_q   <= {DATA_W{1'b0}};
      ex_wd_q     <= REG_ZERO;
      ex_wreg_q   <= 1'b0;
      ex_pc_q     <= {DATA_W{1'b0}};
      ex_valid_q  <= 1'b0;
      invalid_q   <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_aluop_q  <= ex_aluop_d;
      ex_alusel_q <= ex_alusel_d;
      ex_reg1_q   <= ex_reg1_d;
      ex_reg2_q   <= ex_reg2_d;
      ex_wd_q     <= ex_wd_d;
      ex_wreg_q   <= ex_wreg_d;
      ex_pc_q     <= ex_pc_d;
      ex_valid_q  <= ex_valid_d;
      invalid_q   <= invalid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_aluop_o     = ex_aluop_q;
  assign ex_alusel_o    = ex_alusel_q;
  assign ex_reg1_o      = ex_reg1_q;
  assign ex_reg2_o      = ex_reg2_q;
  assign ex_wd_o        = ex_wd_q;
  assign ex_wreg_o      = ex_wreg_q;
  assign ex_pc_o        = ex_pc_q;
  assign ex_valid_o     = ex_valid_q;
  assign invalid_inst_o = invalid_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Testbench for id_stage_pipe: directed cases plus randomized traffic. The
// stimulus side computes each expected ID/EX state from the instruction it
// meant to issue and queues it; a monitor compares it after the clock edge.
module tb_id_stage_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 2;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst, id_valid_i, ex_load_i, stall_i, flush_i;
  logic [DW-1:0]     pc_i, reg1_data_i, reg2_data_i;
  logic [31:0]       inst_i;
  logic [AW-1:0]     reg1_addr_o, reg2_addr_o, ex_load_wd_i, ex_wd_o;
  logic              reg1_read_o, reg2_read_o, stallreq_o, ex_wreg_o, ex_valid_o, invalid_inst_o;
  logic [NF-1:0]     fwd_wreg_i;
  logic [NF*AW-1:0]  fwd_wd_i;
  logic [NF*DW-1:0]  fwd_wdata_i;
  logic [7:0]        ex_aluop_o;
  logic [2:0]        ex_alusel_o;
  logic [DW-1:0]     ex_reg1_o, ex_reg2_o, ex_pc_o;
  logic [CW-1:0]     stall_cnt_o;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .FWD_PORTS(NF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_load_i(ex_load_i), .ex_load_wd_i(ex_load_wd_i),
    .stall_i(stall_i), .flush_i(flush_i), .stallreq_o(stallreq_o),
    .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
    .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
    .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o), .ex_pc_o(ex_pc_o), .ex_valid_o(ex_valid_o),
    .invalid_inst_o(invalid_inst_o), .stall_cnt_o(stall_cnt_o)
  );

  // Instruction table: format, opcode/funct, expected op/select, immediate kind
  localparam logic [1:0] K_R = 2'd0, K_SH = 2'd1, K_I = 2'd2;
  localparam logic [1:0] IM_Z = 2'd0, IM_S = 2'd1, IM_L = 2'd2;
  typedef struct packed {
    logic [1:0] kind; logic [5:0] code; logic [7:0] aluop; logic [2:0] alusel; logic [1:0] immk;
  } op_t;
  op_t optab[20];
  localparam int I_OR = 0, I_ADDU = 7, I_SUBU = 8, I_SRA = 12, I_ORI = 13, I_SLTI = 18;

  typedef struct packed {
    logic [7:0] aluop; logic [2:0] alusel; logic [31:0] r1; logic [31:0] r2;
    logic [4:0] wd; logic wreg; logic [31:0] pc; logic valid; logic inv; logic [15:0] cnt;
  } exp_t;
  typedef struct { int cyc; exp_t e; } sb_t;

  sb_t  sbq[$];
  sb_t  mon_ent;
  exp_t mon_got;
  exp_t mdl;
  int   m_cnt = 0;
  int   cyc = 0;
  int   n_checks = 0, n_pass = 0;
  int   cur_op;
  logic [4:0]  f_rs, f_rt, f_rd, f_sa;
  logic [15:0] f_imm;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
  endtask

  task automatic set_inst(input int op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm);
    cur_op = op; f_rs = rs; f_rt = rt; f_rd = rd; f_sa = sa; f_imm = imm;
    case (optab[op].kind)
      K_R:     inst_i = {6'b000000, rs, rt, rd, 5'b00000, optab[op].code};
      K_SH:    inst_i = {6'b000000, 5'b00000, rt, rd, sa, optab[op].code};
      default: inst_i = {optab[op].code, rs, rt, imm};
    endcase
  endtask

  task automatic set_bad(input logic [31:0] w);
    cur_op = -1; inst_i = w;
  endtask

  task automatic set_fwd(input int k, input logic en, input logic [4:0] wd, input logic [31:0] d);
    fwd_wreg_i[k] = en; fwd_wd_i[k*AW +: AW] = wd; fwd_wdata_i[k*DW +: DW] = d;
  endtask

  // Value the instruction should see for a source register
  function automatic logic [31:0] src_val(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    for (int k = 0; k < NF; k++)
      if (fwd_wreg_i[k] && fwd_wd_i[k*AW +: AW] == a) return fwd_wdata_i[k*DW +: DW];
    return rf;
  endfunction

  // Called just after a falling edge with inputs set: check combinational
  // outputs, advance the model, queue the expected state, then go to the next falling edge.
  task automatic step(input bit do_push);
    logic rd1, rd2, hz;
    logic [4:0] a1, a2;
    logic [31:0] v1, v2, imm32;
    exp_t nx;
    op_t o;
    sb_t ent;
    rd1 = 1'b0; rd2 = 1'b0; a1 = 5'd0; a2 = 5'd0; v1 = 32'd0; v2 = 32'd0; nx = '0; hz = 1'b0;
    if (cur_op >= 0 && id_valid_i) begin
      o = optab[cur_op];
      case (o.immk)
        IM_Z:    imm32 = {16'h0000, f_imm};
        IM_S:    imm32 = {{16{f_imm[15]}}, f_imm};
        default: imm32 = {f_imm, 16'h0000};
      endcase
      if (o.kind == K_R) begin rd1 = 1'b1; rd2 = 1'b1; a1 = f_rs; a2 = f_rt; nx.wd = f_rd; end
      else if (o.kind == K_SH) begin rd2 = 1'b1; a2 = f_rt; v1 = {27'd0, f_sa}; nx.wd = f_rd; end
      else begin rd1 = 1'b1; a1 = f_rs; v2 = imm32; nx.wd = f_rt; end
      if (rd1) v1 = src_val(a1, reg1_data_i);
      if (rd2) v2 = src_val(a2, reg2_data_i);
      nx.aluop = o.aluop; nx.alusel = o.alusel; nx.r1 = v1; nx.r2 = v2;
      nx.wreg = (nx.wd != 5'd0); nx.pc = pc_i; nx.valid = 1'b1;
      hz = ex_load_i && (ex_load_wd_i != 5'd0) &&
           ((rd1 && a1 == ex_load_wd_i) || (rd2 && a2 == ex_load_wd_i));
    end
    if (rst) hz = 1'b0;
    #1;
    if (do_push)
      chk("comb_rd_stallreq", {147'd0, stallreq_o, reg1_read_o, reg1_addr_o, reg2_read_o, reg2_addr_o},
          {147'd0, hz, rd1, a1, rd2, a2});
    if (rst) begin
      mdl = '0; m_cnt = 0;
    end else begin
      if (hz) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (flush_i) mdl = '0;
      else if (stall_i) mdl.inv = 1'b0;
      else if (hz || !id_valid_i) mdl = '0;
      else if (cur_op < 0) begin mdl = '0; mdl.inv = 1'b1; end
      else mdl = nx;
    end
    mdl.cnt = 16'(m_cnt);
    if (do_push) begin
      ent.cyc = cyc + 1; ent.e = mdl;
      sbq.push_back(ent);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: after each rising edge compare the DUT against queued expectations
  always @(posedge clk) begin
    cyc++;
    #1;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_ent = sbq.pop_front();
      mon_got = {ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
                 ex_pc_o, ex_valid_o, invalid_inst_o, stall_cnt_o};
      if (mon_ent.cyc != cyc) chk("sb_timing", 160'(cyc), 160'(mon_ent.cyc));
      else chk("ex_state", 160'(mon_got), 160'(mon_ent.e));
    end
  end

  task automatic rand_inputs();
    logic [31:0] w;
    rst          = ($urandom_range(49, 0) == 0);
    flush_i      = ($urandom_range(15, 0) == 0);
    stall_i      = ($urandom_range(7, 0) == 0);
    id_valid_i   = ($urandom_range(3, 0) != 0);
    ex_load_i    = ($urandom_range(3, 0) == 0);
    ex_load_wd_i = 5'($urandom_range(7, 0));
    pc_i         = $urandom;
    reg1_data_i  = $urandom;
    reg2_data_i  = $urandom;
    for (int k = 0; k < NF; k++)
      set_fwd(k, 1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom);
    if ($urandom_range(15, 0) == 0) begin
      case ($urandom_range(2, 0))
        0:       w = {6'b111111, 26'($urandom)};
        1:       w = {6'b000000, 15'($urandom), 5'($urandom_range(31, 1)), 6'b100101};
        default: w = {6'b000000, 5'($urandom_range(31, 1)), 10'($urandom), 5'd3, 6'b000000};
      endcase
      set_bad(w);
    end else begin
      set_inst($urandom_range(19, 0), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
               5'($urandom_range(7, 0)), 5'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    optab[0]  = '{K_R,  6'b100101, 8'h25, 3'b001, IM_Z};
    optab[1]  = '{K_R,  6'b100100, 8'h24, 3'b001, IM_Z};
    optab[2]  = '{K_R,  6'b100110, 8'h26, 3'b001, IM_Z};
    optab[3]  = '{K_R,  6'b100111, 8'h27, 3'b001, IM_Z};
    optab[4]  = '{K_R,  6'b000100, 8'h7C, 3'b010, IM_Z};
    optab[5]  = '{K_R,  6'b000110, 8'h02, 3'b010, IM_Z};
    optab[6]  = '{K_R,  6'b000111, 8'h03, 3'b010, IM_Z};
    optab[7]  = '{K_R,  6'b100001, 8'h21, 3'b100, IM_Z};
    optab[8]  = '{K_R,  6'b100011, 8'h23, 3'b100, IM_Z};
    optab[9]  = '{K_R,  6'b101010, 8'h2A, 3'b100, IM_Z};
    optab[10] = '{K_SH, 6'b000000, 8'h7C, 3'b010, IM_Z};
    optab[11] = '{K_SH, 6'b000010, 8'h02, 3'b010, IM_Z};
    optab[12] = '{K_SH, 6'b000011, 8'h03, 3'b010, IM_Z};
    optab[13] = '{K_I,  6'b001101, 8'h25, 3'b001, IM_Z};
    optab[14] = '{K_I,  6'b001100, 8'h24, 3'b001, IM_Z};
    optab[15] = '{K_I,  6'b001110, 8'h26, 3'b001, IM_Z};
    optab[16] = '{K_I,  6'b001111, 8'h25, 3'b001, IM_L};
    optab[17] = '{K_I,  6'b001001, 8'h56, 3'b100, IM_S};
    optab[18] = '{K_I,  6'b001010, 8'h2A, 3'b100, IM_S};
    optab[19] = '{K_I,  6'b100011, 8'hE3, 3'b111, IM_S};
    mdl = '0;

    // Reset for two cycles with a would-be hazard present
    rst = 1'b1; id_valid_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    pc_i = 32'h0000_0100; reg1_data_i = 32'd0; reg2_data_i = 32'd0;
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0;
    ex_load_i = 1'b1; ex_load_wd_i = 5'd5;
    set_inst(I_SUBU, 5'd5, 5'd7, 5'd6, 5'd0, 16'h0);
    @(negedge clk);
    step(1); step(1);
    rst = 1'b0; ex_load_i = 1'b0;

    // ORI $1,$0,0x1100 then OR $2,$1,$1 forwarded from port 0 over a stale regfile
    set_inst(I_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1100); step(1);
    pc_i = 32'h0000_0104; set_fwd(0, 1'b1, 5'd1, 32'h0000_1100);
    set_inst(I_OR, 5'd1, 5'd1, 5'd2, 5'd0, 16'h0); step(1);

    // Both ports target $3: port 0 wins; then everything on $0
    pc_i = 32'h0000_0108; set_fwd(0, 1'b1, 5'd3, 32'hA); set_fwd(1, 1'b1, 5'd3, 32'hB);
    set_inst(I_ADDU, 5'd3, 5'd3, 5'd4, 5'd0, 16'h0); step(1);
    set_fwd(0, 1'b1, 5'd0, 32'hA); set_fwd(1, 1'b1, 5'd0, 32'hB);
    set_inst(I_ADDU, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0); step(1);
    fwd_wreg_i = '0;

    // Load-use: SUBU $6,$5,$7 behind LW $5 stalls once, then latches
    ex_load_i = 1'b1; ex_load_wd_i = 5'd5; reg1_data_i = 32'h55; reg2_data_i = 32'h77;
    set_inst(I_SUBU, 5'd5, 5'd7, 5'd6, 5'd0, 16'h0); step(1);
    ex_load_i = 1'b0; step(1);

    // Sign-extended immediate and shift-by-immediate
    set_inst(I_SLTI, 5'd9, 5'd8, 5'd0, 5'd0, 16'hFFFF); step(1);
    set_inst(I_SRA, 5'd0, 5'd2, 5'd1, 5'd31, 16'h0); step(1);

    // Undecodable instruction: one-cycle pulse and bubble
    set_bad(32'hFC12_3456); step(1);
    set_inst(I_OR, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0); step(1);

    // Hold for three cycles, then flush wins over hold
    stall_i = 1'b1; set_inst(I_ADDU, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0); pc_i = 32'h200;
    step(1); step(1); step(1);
    flush_i = 1'b1; step(1);
    flush_i = 1'b0; stall_i = 1'b0; step(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step(1);
    end

    // Reset in the middle of a stall
    rst = 1'b0; flush_i = 1'b0; stall_i = 1'b0; id_valid_i = 1'b1; fwd_wreg_i = '0;
    ex_load_i = 1'b1; ex_load_wd_i = 5'd5;
    set_inst(I_SUBU, 5'd5, 5'd7, 5'd6, 5'd0, 16'h0);
    step(1); step(1);
    rst = 1'b1; step(1);
    rst = 1'b0; step(1);

    // Hold the stall condition long enough to saturate the counter
    for (int i = 0; i < 65539; i++) begin
      step((i % 8192 == 0) || (i >= 65530));
    end
    ex_load_i = 1'b0; step(1);

    repeat (3) @(negedge clk);
    chk("sb_drained", 160'(sbq.size()), 160'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
